interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 15, the number of interrupt sources; legal range 1..16.
REQ-002 SHALL have parameter BASE_ADDR, default 12'hF00, the first address of the register window.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port event_in, input, NUM_SOURCES, one-cycle event pulses from the timers, buttons and sound sources.
REQ-006 SHALL have port bus_addr, input, 12, CPU memory address.
REQ-007 SHALL have port bus_write_en, input, 1, CPU write strobe.
REQ-008 SHALL have port bus_read_en, input, 1, CPU read strobe, one cycle per read access.
REQ-009 SHALL have port bus_write_data, input, 4, CPU write nibble.
REQ-010 SHALL have port bus_read_data, output, 4, read nibble, combinational from bus_addr.
REQ-011 SHALL have port bus_hit, output, 1, high when bus_addr is inside the window; the top level uses it to select bus_read_data over RAM.
REQ-012 SHALL have port interrupt_req, output, NUM_SOURCES, registered level requests to the CPU.

Function
REQ-013 SHALL hold one factor flag and one mask bit per source.
REQ-014 SHALL map the window as follows:
- factor nibbles at BASE_ADDR+0..3; source n is bit n%4 of nibble n/4.
- mask nibbles at BASE_ADDR+8..B.
- all other window addresses read 0 and ignore writes.
REQ-015 SHALL read 0 for any bit index ≥ NUM_SOURCES.
REQ-016 SHALL set a factor flag on the clk edge where its event_in bit is 1, regardless of the mask.
REQ-017 SHALL clear every flag of a factor nibble on the edge where bus_read_en=1 and bus_addr selects that nibble (read-to-clear); bus_read_data SHALL show the pre-clear value in that cycle.
REQ-018 SHALL give set priority when set and clear coincide on one flag in one cycle; the flag stays 1.
REQ-019 SHALL ignore writes to factor nibbles.
REQ-020 SHALL load mask bits from bus_write_data on the edge where bus_write_en=1 and bus_addr selects that mask nibble.
REQ-021 SHALL read mask nibbles back with no side effect.
REQ-022 SHALL register interrupt_req = flag AND mask, so a request is visible one cycle after the edge that changed a flag or mask bit.
REQ-023 SHALL ignore a simultaneous bus_read_en and bus_write_en, with no read clear and no write.
REQ-024 SHALL keep a flag set until it is cleared by a read, regardless of repeated events; there is no event counting.
REQ-025 SHALL assert bus_hit for bus_addr in BASE_ADDR..BASE_ADDR+15 and drive bus_read_data=0 when bus_hit=0.

Reset
REQ-026 SHALL clear all flags, all masks and interrupt_req on any edge with reset_n=0.
REQ-027 SHALL give reset priority over events and bus accesses in the same cycle.
REQ-028 SHALL leave bus_read_data and bus_hit combinational and unaffected by reset.
REQ-029 SHALL hold interrupt_req at 0 on the first edge after reset_n rises; an event on that edge appears on interrupt_req one cycle later.

Structure
REQ-030 SHALL take INT_BASE_ADDR, INT_FACTOR_OFFSET (0) and INT_MASK_OFFSET (8) from the shared types package.
REQ-031 SHALL keep the per-nibble flag/mask/clear logic in one sub-module, int_flag_group (4 sources), instantiated ceil(NUM_SOURCES/4) times.

Verification
REQ-032 Bench SHALL cover set and clear: pulse event_in[5]; mask nibble 9 = 4'b0010 → interrupt_req[5]=1 two cycles after the pulse; read of addr F01 returns 4'b0010 and interrupt_req[5]=0 one cycle later.
REQ-033 Bench SHALL cover masked pending: pulse event_in[2] with mask 0 → interrupt_req=0; write F08=4'b0100 → interrupt_req[2]=1 the next cycle.
REQ-034 Bench SHALL cover a collision: event_in[0] pulses in the same cycle as a read of F00 → read data bit0 = old value and flag[0]=1 after the edge.
REQ-035 Bench SHALL cover mid-operation reset: flags 15'h7FFF and masks all 1, then assert reset_n=0 for one cycle → interrupt_req=0 and all reads return 0.
REQ-036 Bench SHALL cover the window edges: write F03=4'hF → no effect, and F03 reads bit3=0 when NUM_SOURCES=15; read of FF0 → bus_hit=0 and data 0; read of F0F → bus_hit=1 and data 0.
REQ-037 Bench SHALL cover bus contention: bus_read_en and bus_write_en both high on F08 → mask unchanged and no flag cleared.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and register-window constants for the interrupt controller.
package interrupt_ctrl_pkg;

    localparam logic [11:0] INT_BASE_ADDR     = 12'hF00;
    localparam logic [3:0]  INT_FACTOR_OFFSET = 4'h0;
    localparam logic [3:0]  INT_MASK_OFFSET   = 4'h8;
    localparam int          INT_GROUP_WIDTH   = 4;
    localparam int          INT_MAX_SOURCES   = 16;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_FACTOR = 2'd1,
        REG_MASK   = 2'd2
    } reg_kind_e;

    typedef struct packed {
        logic      hit;
        reg_kind_e kind;
        logic [1:0] group;
    } bus_decode_t;

    // Window decode; the 13-bit difference keeps addresses below the base from
    // aliasing into the window.
    function automatic bus_decode_t decode_addr(input logic [11:0] addr,
                                                input logic [11:0] base);
        logic [12:0] diff;
        bus_decode_t d;
        diff    = {1'b0, addr} - {1'b0, base};
        d.hit   = (diff < 13'd16);
        d.group = diff[1:0];
        d.kind  = REG_NONE;
        if (d.hit) begin
            if (diff[3:2] == INT_FACTOR_OFFSET[3:2]) begin
                d.kind = REG_FACTOR;
            end else if (diff[3:2] == INT_MASK_OFFSET[3:2]) begin
                d.kind = REG_MASK;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// CPU-side register bus of the interrupt controller.
interface interrupt_ctrl_if;

    logic [11:0] bus_addr;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [3:0]  bus_write_data;
    logic [3:0]  bus_read_data;
    logic        bus_hit;

    modport master (
        output bus_addr, bus_write_en, bus_read_en, bus_write_data,
        input  bus_read_data, bus_hit
    );

    modport slave (
        input  bus_addr, bus_write_en, bus_read_en, bus_write_data,
        output bus_read_data, bus_hit
    );

endinterface

// File: rtl/interrupt_ctrl_flag_group.sv
// One nibble of interrupt sources: factor flags, mask bits and registered requests.
module int_flag_group #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] event_in,
    input  logic             clr_flags,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_wdata,
    output logic [WIDTH-1:0] flags,
    output logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] irq
);

    // Factor flags: read clears the nibble, a same-cycle event wins over the clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags <= '0;
        end else begin
            flags <= (clr_flags ? '0 : flags) | event_in;
        end
    end

    // Mask bits loaded by CPU writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    // Requests registered from the current flag and mask state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= '0;
        end else begin
            irq <= flags & mask;
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: per-source latched factors, masks and a 16-nibble CPU window.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int          NUM_SOURCES = 15,
    parameter logic [11:0] BASE_ADDR   = INT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] event_in,
    interrupt_ctrl_if.slave        bus,
    output logic [NUM_SOURCES-1:0] interrupt_req
);

    localparam int NUM_GROUPS = (NUM_SOURCES + INT_GROUP_WIDTH - 1) / INT_GROUP_WIDTH;

    bus_decode_t            dec;
    logic                   read_ok;
    logic                   write_ok;
    logic [NUM_GROUPS-1:0]  grp_clr;
    logic [NUM_GROUPS-1:0]  grp_mask_we;
    logic [NUM_SOURCES-1:0] flags_flat;
    logic [NUM_SOURCES-1:0] mask_flat;
    logic [3:0]             rd_nibble;

    // Address decode of the register window.
    always_comb begin
        dec = decode_addr(bus.bus_addr, BASE_ADDR);
    end

    assign bus.bus_hit = dec.hit;

    // A cycle with both strobes is treated as no access at all.
    assign read_ok  = bus.bus_read_en  & ~bus.bus_write_en;
    assign write_ok = bus.bus_write_en & ~bus.bus_read_en;

    // Per-nibble read-clear and mask-write strobes.
    always_comb begin
        grp_clr     = '0;
        grp_mask_we = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (int'(dec.group) == g) begin
                grp_clr[g]     = read_ok  && (dec.kind == REG_FACTOR);
                grp_mask_we[g] = write_ok && (dec.kind == REG_MASK);
            end
        end
    end

    // Read mux; bits beyond NUM_SOURCES and non-register addresses stay 0.
    always_comb begin
        rd_nibble = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if ((i / INT_GROUP_WIDTH) == int'(dec.group)) begin
                if (dec.kind == REG_FACTOR) begin
                    rd_nibble[i % INT_GROUP_WIDTH] = flags_flat[i];
                end else if (dec.kind == REG_MASK) begin
                    rd_nibble[i % INT_GROUP_WIDTH] = mask_flat[i];
                end
            end
        end
    end

    assign bus.bus_read_data = rd_nibble;

    // The last group is narrowed so no unused source bits exist.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        localparam int LO = g * INT_GROUP_WIDTH;
        localparam int W  = ((NUM_SOURCES - LO) >= INT_GROUP_WIDTH) ? INT_GROUP_WIDTH
                                                                    : (NUM_SOURCES - LO);
        int_flag_group #(
            .WIDTH (W)
        ) u_group (
            .clk        (clk),
            .reset_n    (reset_n),
            .event_in   (event_in[LO +: W]),
            .clr_flags  (grp_clr[g]),
            .mask_we    (grp_mask_we[g]),
            .mask_wdata (bus.bus_write_data[W-1:0]),
            .flags      (flags_flat[LO +: W]),
            .mask       (mask_flat[LO +: W]),
            .irq        (interrupt_req[LO +: W])
        );
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl with a bit-vector reference model.
module tb_interrupt_ctrl;

    localparam int          NS    = 15;
    localparam logic [15:0] VALID = 16'h7FFF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NS-1:0] event_in;
    logic [NS-1:0] interrupt_req;

    interrupt_ctrl_if bus_if ();

    interrupt_ctrl #(
        .NUM_SOURCES (NS),
        .BASE_ADDR   (12'hF00)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .event_in      (event_in),
        .bus           (bus_if),
        .interrupt_req (interrupt_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_flag = '0;
    logic [15:0] m_mask = '0;
    logic [15:0] m_irq  = '0;

    function automatic logic exp_hit(input logic [11:0] a);
        return (a >= 12'hF00) && (a <= 12'hF0F);
    endfunction

    function automatic int addr_off(input logic [11:0] a);
        return int'({20'd0, a}) - 32'h0F00;
    endfunction

    function automatic logic [3:0] exp_read(input logic [11:0] a);
        int off;
        if (!exp_hit(a)) return 4'h0;
        off = addr_off(a);
        if (off < 4) return m_flag[off*4 +: 4];
        if (off >= 8 && off < 12) return m_mask[(off-8)*4 +: 4];
        return 4'h0;
    endfunction

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic tick();
        logic [15:0] nf, nm, ni;
        int off;
        nf  = m_flag;
        nm  = m_mask;
        ni  = m_flag & m_mask;
        off = addr_off(bus_if.bus_addr);
        if (!reset_n) begin
            nf = '0; nm = '0; ni = '0;
        end else begin
            if (exp_hit(bus_if.bus_addr) && !(bus_if.bus_read_en && bus_if.bus_write_en)) begin
                if (bus_if.bus_read_en && off < 4) nf[off*4 +: 4] = 4'h0;
                if (bus_if.bus_write_en && off >= 8 && off < 12)
                    nm[(off-8)*4 +: 4] = bus_if.bus_write_data;
            end
            nf = (nf | {1'b0, event_in}) & VALID;
            nm = nm & VALID;
        end
        @(posedge clk);
        m_flag = nf;
        m_mask = nm;
        m_irq  = ni;
        #1;
    endtask

    task automatic idle();
        event_in              = '0;
        bus_if.bus_addr       = 12'h000;
        bus_if.bus_read_en    = 1'b0;
        bus_if.bus_write_en   = 1'b0;
        bus_if.bus_write_data = 4'h0;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [3:0] d);
        bus_if.bus_addr = a; bus_if.bus_write_data = d;
        bus_if.bus_write_en = 1'b1; bus_if.bus_read_en = 1'b0;
        tick();
        idle();
    endtask

    task automatic bus_read_clr(input logic [11:0] a);
        bus_if.bus_addr = a; bus_if.bus_read_en = 1'b1; bus_if.bus_write_en = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        event_in = NS'($urandom);
        bus_if.bus_addr = 12'hF08; bus_if.bus_write_en = 1'b1; bus_if.bus_write_data = 4'hF;
        tick();
        tick();
        reset_n = 1'b1;
        idle();
        #1;
        checks++;
        if (interrupt_req !== '0) begin
            errors++; $display("FAIL reset_irq: got %h expected 0", interrupt_req);
        end
        for (int a = 0; a < 16; a++) begin
            bus_if.bus_addr = 12'hF00 + 12'(a);
            #1;
            checks++;
            if (bus_if.bus_read_data !== 4'h0 || bus_if.bus_hit !== 1'b1) begin
                errors++;
                $display("FAIL reset_read addr=%h: got data %h hit %b expected 0 hit 1",
                         bus_if.bus_addr, bus_if.bus_read_data, bus_if.bus_hit);
            end
        end
        idle();
        event_in[3] = 1'b1;
        tick();
        idle();
        checks++;
        if (interrupt_req !== '0) begin
            errors++; $display("FAIL first_edge_irq: got %h expected 0", interrupt_req);
        end
        bus_if.bus_addr = 12'hF00;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'b1000) begin
            errors++; $display("FAIL first_edge_flag: got %b expected 1000", bus_if.bus_read_data);
        end
        bus_read_clr(12'hF00);
        tick();
    endtask

    task automatic test_set_clear();
        bus_write(12'hF09, 4'b0010);
        event_in[5] = 1'b1;
        tick();
        idle();
        checks++;
        if (interrupt_req[5] !== 1'b0) begin
            errors++; $display("FAIL set_irq_early: got %b expected 0", interrupt_req[5]);
        end
        tick();
        checks++;
        if (interrupt_req[5] !== 1'b1 || interrupt_req !== m_irq[NS-1:0]) begin
            errors++; $display("FAIL set_irq: got %h expected %h", interrupt_req, m_irq[NS-1:0]);
        end
        bus_if.bus_addr = 12'hF01; bus_if.bus_read_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'b0010) begin
            errors++; $display("FAIL read_f01: got %b expected 0010", bus_if.bus_read_data);
        end
        tick();
        idle();
        tick();
        checks++;
        if (interrupt_req[5] !== 1'b0 || interrupt_req !== m_irq[NS-1:0]) begin
            errors++; $display("FAIL clear_irq: got %h expected %h", interrupt_req, m_irq[NS-1:0]);
        end
    endtask

    task automatic test_masked_pending();
        event_in[2] = 1'b1;
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (interrupt_req !== '0) begin
            errors++; $display("FAIL masked_irq: got %h expected 0", interrupt_req);
        end
        bus_write(12'hF08, 4'b0100);
        tick();
        checks++;
        if (interrupt_req[2] !== 1'b1 || interrupt_req !== m_irq[NS-1:0]) begin
            errors++; $display("FAIL unmask_irq: got %h expected %h", interrupt_req, m_irq[NS-1:0]);
        end
        bus_read_clr(12'hF00);
        tick();
    endtask

    task automatic test_collision();
        for (int rep = 0; rep < 2; rep++) begin
            logic [3:0] exp_old;
            exp_old = exp_read(12'hF00);
            event_in[0] = 1'b1;
            bus_if.bus_addr = 12'hF00; bus_if.bus_read_en = 1'b1;
            #1;
            checks++;
            if (bus_if.bus_read_data[0] !== exp_old[0] || exp_old[0] !== 1'(rep)) begin
                errors++;
                $display("FAIL collision_old rep=%0d: got %b expected %b",
                         rep, bus_if.bus_read_data[0], 1'(rep));
            end
            tick();
            idle();
            bus_if.bus_addr = 12'hF00;
            #1;
            checks++;
            if (bus_if.bus_read_data[0] !== 1'b1) begin
                errors++; $display("FAIL collision_set rep=%0d: got %b expected 1",
                                   rep, bus_if.bus_read_data[0]);
            end
        end
        bus_read_clr(12'hF00);
        tick();
    endtask

    task automatic test_mid_reset();
        event_in = 15'h7FFF;
        tick();
        idle();
        for (int n = 0; n < 4; n++) bus_write(12'hF08 + 12'(n), 4'hF);
        tick();
        checks++;
        if (interrupt_req !== 15'h7FFF) begin
            errors++; $display("FAIL full_irq: got %h expected 7fff", interrupt_req);
        end
        reset_n = 1'b0;
        event_in = 15'h7FFF;
        bus_if.bus_addr = 12'hF08; bus_if.bus_write_en = 1'b1; bus_if.bus_write_data = 4'hF;
        tick();
        reset_n = 1'b1;
        idle();
        checks++;
        if (interrupt_req !== '0) begin
            errors++; $display("FAIL midreset_irq: got %h expected 0", interrupt_req);
        end
        tick();
        checks++;
        if (interrupt_req !== '0) begin
            errors++; $display("FAIL midreset_irq2: got %h expected 0", interrupt_req);
        end
        for (int a = 0; a < 16; a++) begin
            bus_if.bus_addr = 12'hF00 + 12'(a);
            #1;
            checks++;
            if (bus_if.bus_read_data !== 4'h0) begin
                errors++; $display("FAIL midreset_read addr=%h: got %h expected 0",
                                   bus_if.bus_addr, bus_if.bus_read_data);
            end
        end
        idle();
    endtask

    task automatic test_window_edges();
        event_in = 15'h7000;
        tick();
        idle();
        bus_write(12'hF03, 4'hF);
        bus_write(12'hF04, 4'hF);
        bus_if.bus_addr = 12'hF03;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'b0111) begin
            errors++; $display("FAIL f03_read: got %b expected 0111", bus_if.bus_read_data);
        end
        bus_if.bus_addr = 12'hF04;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'h0 || bus_if.bus_hit !== 1'b1) begin
            errors++; $display("FAIL f04_read: got %h hit %b expected 0 hit 1",
                               bus_if.bus_read_data, bus_if.bus_hit);
        end
        bus_if.bus_addr = 12'hFF0; bus_if.bus_read_en = 1'b1;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'h0 || bus_if.bus_hit !== 1'b0) begin
            errors++; $display("FAIL ff0_read: got %h hit %b expected 0 hit 0",
                               bus_if.bus_read_data, bus_if.bus_hit);
        end
        bus_if.bus_addr = 12'hF0F;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'h0 || bus_if.bus_hit !== 1'b1) begin
            errors++; $display("FAIL f0f_read: got %h hit %b expected 0 hit 1",
                               bus_if.bus_read_data, bus_if.bus_hit);
        end
        idle();
        bus_read_clr(12'hF03);
        tick();
    endtask

    task automatic test_contention();
        bus_write(12'hF08, 4'b0101);
        event_in[1] = 1'b1;
        tick();
        idle();
        bus_if.bus_addr = 12'hF08; bus_if.bus_read_en = 1'b1; bus_if.bus_write_en = 1'b1;
        bus_if.bus_write_data = 4'b1010;
        tick();
        idle();
        bus_if.bus_addr = 12'hF08;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'b0101) begin
            errors++; $display("FAIL contention_mask: got %b expected 0101", bus_if.bus_read_data);
        end
        bus_if.bus_addr = 12'hF00; bus_if.bus_read_en = 1'b1; bus_if.bus_write_en = 1'b1;
        tick();
        idle();
        bus_if.bus_addr = 12'hF00;
        #1;
        checks++;
        if (bus_if.bus_read_data !== 4'b0010) begin
            errors++; $display("FAIL contention_flag: got %b expected 0010", bus_if.bus_read_data);
        end
        bus_read_clr(12'hF00);
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 19);
            event_in = NS'($urandom & $urandom & $urandom);
            case (r)
                16:      bus_if.bus_addr = 12'hFF0;
                17:      bus_if.bus_addr = 12'hEFF;
                18:      bus_if.bus_addr = 12'hF10;
                19:      bus_if.bus_addr = 12'h000;
                default: bus_if.bus_addr = 12'hF00 + 12'(r);
            endcase
            bus_if.bus_read_en    = ($urandom_range(0, 2) == 0);
            bus_if.bus_write_en   = ($urandom_range(0, 2) == 0);
            bus_if.bus_write_data = 4'($urandom);
            reset_n               = ($urandom_range(0, 49) != 0);
            #1;
            checks++;
            if (bus_if.bus_read_data !== exp_read(bus_if.bus_addr) ||
                bus_if.bus_hit !== exp_hit(bus_if.bus_addr)) begin
                errors++;
                $display("FAIL rand_read it=%0d addr=%h: got %h hit %b expected %h hit %b",
                         it, bus_if.bus_addr, bus_if.bus_read_data, bus_if.bus_hit,
                         exp_read(bus_if.bus_addr), exp_hit(bus_if.bus_addr));
            end
            tick();
            checks++;
            if (interrupt_req !== m_irq[NS-1:0]) begin
                errors++;
                $display("FAIL rand_irq it=%0d: got %h expected %h", it, interrupt_req, m_irq[NS-1:0]);
            end
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_set_clear();
        test_masked_pending();
        test_collision();
        test_mid_reset();
        test_window_edges();
        test_contention();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
